// File: rtl/spike_aer_encoder_pkg.sv
// Shared definitions for the spike-to-AER encoder: parameter defaults,
// FSM state encoding and the address-width helper.
package spike_aer_encoder_pkg;

    localparam int N_IN_DEF    = 32;
    localparam int FRAME_W_DEF = 16;
    localparam int DROP_W      = 8;

    // IDLE: nothing pending; EMIT: pending bits nonzero; DONE: one-cycle frame end
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Address width for n inputs; never below one bit so a 1-input build stays legal
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spike_aer_encoder_if.sv
// Address-event output bus of the spike encoder.
//
// Handshake: the master raises valid with addr/frame/last stable; the event
// transfers on any rising clk edge where valid and ready are both high. While
// valid is high and ready is low, addr, frame and last do not change. ready
// has no effect while valid is low.
interface spike_aer_encoder_if
    import spike_aer_encoder_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int FRAME_W = FRAME_W_DEF
);
    localparam int AW = addr_w(N_IN);

    logic               valid;
    logic               ready;
    logic [AW-1:0]      addr;
    logic [FRAME_W-1:0] frame;
    logic               last;

    modport master (output valid, output addr, output frame, output last, input ready);
    modport slave  (input valid, input addr, input frame, input last, output ready);

endinterface

// File: rtl/spike_aer_encoder_prio_enc.sv
// Lowest-set-bit priority encoder: index and one-hot of the least
// significant set bit, plus an any-set flag.
module spike_prio_enc
    import spike_aer_encoder_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int AW   = addr_w(N_IN)
) (
    input  logic [N_IN-1:0] i_vec,
    output logic [AW-1:0]   o_idx,
    output logic [N_IN-1:0] o_onehot,
    output logic            o_any
);

    // two's-complement trick isolates the lowest set bit
    assign o_onehot = i_vec & (~i_vec + N_IN'(1));
    assign o_any    = |i_vec;

    // scan from the top so the lowest set bit is the final assignment
    always_comb begin
        o_idx = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (i_vec[i]) o_idx = AW'(i);
        end
    end

endmodule

// File: rtl/spike_aer_encoder.sv
// Converts one spike vector per time step into a stream of address events,
// lowest index first, tagged with a frame id. Frames that arrive while a
// frame is still being emitted are dropped and counted.
// All outputs are registered; the event presented next cycle is encoded from
// the pending vector as it will be after this cycle's load/accept.
// frame_done pulses in the cycle after the final event is accepted (or after
// an all-zero frame is taken), including when a new frame is loaded on that
// same final-accept edge.
module spike_aer_encoder
    import spike_aer_encoder_pkg::*;
#(
    parameter int N_IN    = N_IN_DEF,
    parameter int FRAME_W = FRAME_W_DEF
) (
    input  logic                clk,
    input  logic                rst_l,
    input  logic [N_IN-1:0]     spike_word,
    input  logic                frame_valid,
    spike_aer_encoder_if.master aer,
    output logic                frame_done,
    output logic                overflow,
    output logic [DROP_W-1:0]   drop_cnt,
    output state_t              dbg_state
);

    localparam int AW = addr_w(N_IN);

    state_t             r_state;
    logic [N_IN-1:0]    r_pending;
    logic [N_IN-1:0]    r_onehot;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic [FRAME_W-1:0] r_cur_frame;
    logic               r_valid;
    logic [AW-1:0]      r_addr;
    logic               r_last;
    logic               r_frame_done;
    logic               r_overflow;
    logic [DROP_W-1:0]  r_drop_cnt;

    logic               w_accept;
    logic               w_final;
    logic               w_load;
    logic               w_drop;
    logic [N_IN-1:0]    w_pending_nxt;
    logic [AW-1:0]      w_idx;
    logic [N_IN-1:0]    w_onehot;
    logic               w_any;
    logic               w_last;

    // a new frame is taken when idle or on the edge that retires the last event
    assign w_accept = r_valid & aer.ready;
    assign w_final  = w_accept & r_last;
    assign w_load   = frame_valid & ((r_state == ST_IDLE) | w_final);
    assign w_drop   = frame_valid & ~w_load;

    // pending vector after this edge: fresh load, accepted bit cleared, or held
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_load) begin
            w_pending_nxt = spike_word;
        end else if (w_accept) begin
            w_pending_nxt = r_pending & ~r_onehot;
        end
    end

    spike_prio_enc #(
        .N_IN (N_IN),
        .AW   (AW)
    ) u_prio_enc (
        .i_vec    (w_pending_nxt),
        .o_idx    (w_idx),
        .o_onehot (w_onehot),
        .o_any    (w_any)
    );

    // exactly one bit remains when removing the lowest one leaves nothing
    assign w_last = w_any & ((w_pending_nxt & ~w_onehot) == '0);

    // frame FSM with registered event outputs and drop bookkeeping
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state      <= ST_IDLE;
            r_pending    <= '0;
            r_onehot     <= '0;
            r_frame_cnt  <= '0;
            r_cur_frame  <= '0;
            r_valid      <= 1'b0;
            r_addr       <= '0;
            r_last       <= 1'b0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_pending    <= w_pending_nxt;
            r_onehot     <= w_onehot;
            r_valid      <= w_any;
            r_addr       <= w_idx;
            r_last       <= w_last;
            r_frame_done <= 1'b0;

            // every offered frame consumes an id, dropped or not
            if (frame_valid) r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
            if (w_load)      r_cur_frame <= r_frame_cnt;

            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != {DROP_W{1'b1}}) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state      <= w_any ? ST_EMIT : ST_DONE;
                        r_frame_done <= ~w_any;
                    end
                end
                ST_EMIT: begin
                    if (w_final) begin
                        r_frame_done <= 1'b1;
                        if (w_load) r_state <= w_any ? ST_EMIT : ST_DONE;
                        else        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign aer.valid  = r_valid;
    assign aer.addr   = r_addr;
    assign aer.frame  = r_cur_frame;
    assign aer.last   = r_last;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;
    assign drop_cnt   = r_drop_cnt;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Bench for spike_aer_encoder: directed frames with literal expectations plus
// a queue-based model of the event stream compared on every falling edge.
module tb_spike_aer_encoder;
    import spike_aer_encoder_pkg::*;

    localparam int N_IN    = 32;
    localparam int FRAME_W = 8;
    localparam int AW_TB   = 5;

    logic              clk;
    logic              rst_l;
    logic [N_IN-1:0]   spike_word;
    logic              frame_valid;
    logic              frame_done;
    logic              overflow;
    logic [7:0]        drop_cnt;
    state_t            dbg_state;

    spike_aer_encoder_if #(.N_IN(N_IN), .FRAME_W(FRAME_W)) aer_if ();

    spike_aer_encoder #(.N_IN(N_IN), .FRAME_W(FRAME_W)) dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .spike_word  (spike_word),
        .frame_valid (frame_valid),
        .aer         (aer_if),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .dbg_state   (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int evt0     = 0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        frame_valid = 1'b0;
        spike_word  = '0;
        rst_l       = 1'b0;
        tick();
        tick();
        rst_l = 1'b1;
        tick();
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (frame_done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check("done_timeout", seen, 1);
    endtask

    // ---------------- behavioural model ----------------
    logic [AW_TB-1:0]   exp_q[$];
    logic [FRAME_W-1:0] m_cur;
    int                 m_cnt;
    bit                 m_done;
    bit                 m_ovf;
    int                 m_drop;

    task automatic model_reset();
        exp_q.delete();
        m_cur  = '0;
        m_cnt  = 0;
        m_done = 1'b0;
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic model_step();
        int sz;
        bit accept, fin, idle, load, nd;
        sz     = exp_q.size();
        accept = (sz > 0) && aer_if.ready;
        fin    = accept && (sz == 1);
        idle   = (sz == 0) && !m_done;
        load   = frame_valid && (idle || fin);
        nd     = 1'b0;
        if (accept) void'(exp_q.pop_front());
        if (frame_valid) begin
            if (load) begin
                m_cur = FRAME_W'(m_cnt);
                for (int i = 0; i < N_IN; i++)
                    if (spike_word[i]) exp_q.push_back(AW_TB'(i));
                if (spike_word == '0) nd = 1'b1;
            end else begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
            m_cnt = (m_cnt + 1) % (1 << FRAME_W);
        end
        if (fin) nd = 1'b1;
        m_done = nd;
    endtask

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (!rst_l) begin
            model_reset();
        end else begin
            check("aer_valid", aer_if.valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                check("aer_addr", aer_if.addr, exp_q[0]);
                check("aer_frame", aer_if.frame, m_cur);
                check("aer_last", aer_if.last, exp_q.size() == 1);
            end
            check("frame_done", frame_done, m_done);
            check("overflow", overflow, m_ovf);
            check("drop_cnt", drop_cnt, m_drop);
            if (aer_if.valid && aer_if.ready && aer_if.frame == '0) evt0++;
            model_step();
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst_l        = 1'b0;
        frame_valid  = 1'b0;
        spike_word   = '0;
        aer_if.ready = 1'b0;
        #2;
        check("rst_valid", aer_if.valid, 0);
        check("rst_addr", aer_if.addr, 0);
        check("rst_frame", aer_if.frame, 0);
        check("rst_last", aer_if.last, 0);
        check("rst_done", frame_done, 0);
        check("rst_ovf", overflow, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_state", dbg_state, ST_IDLE);
        reset_dut();

        // two-bit frame, ready high
        aer_if.ready = 1'b1;
        spike_word = 32'h0000_0005; frame_valid = 1'b1;
        tick(); frame_valid = 1'b0; spike_word = '0;
        check("t1_valid0", aer_if.valid, 1);
        check("t1_addr0", aer_if.addr, 0);
        check("t1_last0", aer_if.last, 0);
        check("t1_frame", aer_if.frame, 0);
        tick();
        check("t1_addr1", aer_if.addr, 2);
        check("t1_last1", aer_if.last, 1);
        tick();
        check("t1_valid_end", aer_if.valid, 0);
        check("t1_done", frame_done, 1);
        tick();
        check("t1_done_off", frame_done, 0);

        // back-pressure holds the event stable
        reset_dut();
        aer_if.ready = 1'b0;
        spike_word = 32'h8000_0001; frame_valid = 1'b1;
        tick(); frame_valid = 1'b0; spike_word = '0;
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_addr", aer_if.addr, 0);
            check("t2_hold_valid", aer_if.valid, 1);
            check("t2_hold_last", aer_if.last, 0);
            tick();
        end
        aer_if.ready = 1'b1;
        check("t2_addr0", aer_if.addr, 0);
        tick();
        check("t2_addr31", aer_if.addr, 31);
        check("t2_last31", aer_if.last, 1);
        tick();
        check("t2_done", frame_done, 1);

        // empty frame, then a frame offered during DONE is dropped
        reset_dut();
        spike_word = '0; frame_valid = 1'b1;
        tick();
        check("t3_valid", aer_if.valid, 0);
        check("t3_done", frame_done, 1);
        spike_word = 32'h0000_0001;
        tick(); frame_valid = 1'b0;
        check("t3_done_off", frame_done, 0);
        check("t3_ovf", overflow, 1);
        check("t3_drop", drop_cnt, 1);
        spike_word = 32'h0000_0002; frame_valid = 1'b1;
        tick(); frame_valid = 1'b0; spike_word = '0;
        check("t3_frame", aer_if.frame, 2);
        check("t3_addr", aer_if.addr, 1);
        wait_done(8);

        // full frame with a second frame arriving mid-emission
        reset_dut();
        evt0 = 0;
        aer_if.ready = 1'b1;
        spike_word = 32'hFFFF_FFFF; frame_valid = 1'b1;
        tick(); frame_valid = 1'b0;
        repeat (7) tick();
        frame_valid = 1'b1;
        tick(); frame_valid = 1'b0; spike_word = '0;
        check("t4_ovf", overflow, 1);
        check("t4_drop", drop_cnt, 1);
        wait_done(64);
        check("t4_events", evt0, 32);
        tick();
        spike_word = 32'h0000_0003; frame_valid = 1'b1;
        tick(); frame_valid = 1'b0; spike_word = '0;
        check("t4_frame", aer_if.frame, 2);
        check("t4_addr", aer_if.addr, 0);
        wait_done(8);

        // new frame on the final accept edge
        reset_dut();
        aer_if.ready = 1'b1;
        spike_word = 32'h0000_0010; frame_valid = 1'b1;
        tick();
        check("t5_addr", aer_if.addr, 4);
        check("t5_last", aer_if.last, 1);
        spike_word = 32'h0000_0300;
        tick(); frame_valid = 1'b0; spike_word = '0;
        check("t5_done", frame_done, 1);
        check("t5_valid", aer_if.valid, 1);
        check("t5_addr8", aer_if.addr, 8);
        check("t5_frame", aer_if.frame, 1);
        check("t5_ovf", overflow, 0);
        tick();
        check("t5_addr9", aer_if.addr, 9);
        check("t5_done_off", frame_done, 0);
        tick();
        check("t5_done2", frame_done, 1);

        // drop saturation and frame id wrap
        reset_dut();
        aer_if.ready = 1'b0;
        spike_word = 32'h0000_0001; frame_valid = 1'b1;
        tick();
        spike_word = 32'hFFFF_FFFF;
        repeat (260) tick();
        frame_valid = 1'b0; spike_word = '0;
        check("t7_drop_sat", drop_cnt, 255);
        check("t7_ovf", overflow, 1);
        check("t7_frame", aer_if.frame, 0);
        aer_if.ready = 1'b1;
        wait_done(8);
        tick();
        spike_word = 32'h0000_0004; frame_valid = 1'b1;
        tick(); frame_valid = 1'b0; spike_word = '0;
        check("t7_wrap_frame", aer_if.frame, 5);
        check("t7_addr", aer_if.addr, 2);
        wait_done(8);

        // asynchronous reset in the middle of a frame
        reset_dut();
        aer_if.ready = 1'b1;
        spike_word = 32'h0000_FFFF; frame_valid = 1'b1;
        tick(); frame_valid = 1'b0; spike_word = '0;
        tick();
        tick();
        check("t6_pre_addr", aer_if.addr, 2);
        rst_l = 1'b0;
        #1;
        check("t6_valid", aer_if.valid, 0);
        check("t6_addr", aer_if.addr, 0);
        check("t6_frame", aer_if.frame, 0);
        check("t6_last", aer_if.last, 0);
        check("t6_done", frame_done, 0);
        check("t6_drop", drop_cnt, 0);
        tick();
        rst_l = 1'b1;
        tick();
        spike_word = 32'h0000_0001; frame_valid = 1'b1;
        tick(); frame_valid = 1'b0; spike_word = '0;
        check("t6_new_frame", aer_if.frame, 0);
        check("t6_new_valid", aer_if.valid, 1);
        wait_done(8);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_aer_encoder.md
SPIKE_AER_ENCODER -- requirements
Module: spike_aer_encoder

Interface
REQ-001 Parameter: N_IN, default 32, number of input spike lines (one bit per input neuron).
REQ-002 Parameter: FRAME_W, default 16, width of the frame (time-step) counter.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst_l  input  1  reset, asynchronous, active-low.
REQ-005 spike_word  input  N_IN  spike vector for one time step, read from spike memory.
REQ-006 frame_valid  input  1  one-cycle pulse; spike_word is valid this cycle.
REQ-007 aer_valid  output  1  an address-event is presented.
REQ-008 aer_ready  input  1  downstream accepts the event when high together with aer_valid.
REQ-009 aer_addr  output  clog2(N_IN)  index of the spiking input.
REQ-010 aer_frame  output  FRAME_W  frame id of the presented event.
REQ-011 aer_last  output  1  high with the final event of a frame.
REQ-012 frame_done  output  1  one-cycle pulse when a frame has been fully emitted.
REQ-013 overflow  output  1  sticky flag; a frame was dropped.
REQ-014 drop_cnt  output  8  saturating count of dropped frames.

Function
REQ-015 FSM states: IDLE (no pending bits), EMIT (pending bits nonzero), DONE (single cycle).
REQ-016 IDLE + frame_valid: load spike_word into pending register, latch frame id, increment frame counter (mod 2^FRAME_W), go to EMIT if word nonzero, else DONE.
REQ-017 Latency: frame_valid in cycle N -> aer_valid high in cycle N+1 with the lowest set bit index.
REQ-018 EMIT: aer_addr = index of lowest set pending bit; events leave in ascending index order.
REQ-019 Handshake: on aer_valid and aer_ready, clear that pending bit; aer_addr, aer_frame and aer_last hold stable while aer_valid and not aer_ready.
REQ-020 aer_last is high iff exactly one pending bit remains.
REQ-021 Last event accepted with no frame_valid in the same cycle: go to DONE.
REQ-022 DONE: frame_done high for one cycle, aer_valid low, then IDLE.
REQ-023 Last event accepted and frame_valid in the same cycle: load the new frame (no drop), pulse frame_done that cycle, next state per REQ-016.
REQ-024 frame_valid in EMIT (not on the final accept) or in DONE: drop the new frame, set overflow, increment drop_cnt and saturate at 255; the current frame is unaffected and the frame counter still increments.
REQ-025 Frame counter wraps 2^FRAME_W-1 -> 0.
REQ-026 aer_ready is ignored when aer_valid is low.

Reset
REQ-027 Asserting rst_l low sets all outputs and state to zero immediately: aer_valid=0, aer_addr=0, aer_frame=0, aer_last=0, frame_done=0, overflow=0, drop_cnt=0, frame counter=0, pending=0, state IDLE.
REQ-028 Reset mid-frame discards pending events; after deassertion the first frame_valid starts frame id 0.

Structure
REQ-029 N_IN, FRAME_W defaults and state encodings live in the shared defines header.
REQ-030 The lowest-set-bit priority encoder (N_IN -> index, plus one-hot) is a separate sub-module, spike_prio_enc.

Verification
REQ-031 spike_word=0x00000005, frame_valid, aer_ready=1 -> addr 0 (last=0), then addr 2 (last=1), frame_done next cycle, aer_frame=0.
REQ-032 spike_word=0x80000001, aer_ready held low 5 cycles -> aer_addr=0 stable throughout; after ready rises, addr 0 then 31.
REQ-033 spike_word=0 -> no aer_valid; frame_done pulses at N+1; frame counter becomes 1.
REQ-034 spike_word=0xFFFFFFFF, frame_valid every 8 cycles, aer_ready=1 -> second frame dropped, overflow=1, drop_cnt=1, only 32 events with aer_frame=0, the next frame loaded carries aer_frame=2.
REQ-035 Single-bit frame 0x00000010, second frame_valid in the same cycle the event is accepted -> no drop, frame_done pulse, next event from the second frame at the following cycle.
REQ-036 Reset asserted mid-emission of 0x0000FFFF -> all outputs 0 at once; the next frame reports aer_frame=0.
